md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_defs.sv | 26 ++
 rtl/md_unit.sv | 176 +++++++++++++++++
 tb/tb_md_unit.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_defs.sv
// md_defs -- shared definitions for the HI/LO multiply/divide unit.
//   md_op_e     : 4-bit operation encoding carried on md_op
//   MULT_CYCLES : busy length of multiply and multiply-accumulate ops
//   DIV_CYCLES  : busy length of divide ops
//   CNT_W       : width of the busy down-counter
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/md_unit.sv
// md_unit -- MIPS-style HI/LO multiply/divide unit.
//
// A launched op computes its full 64-bit result at the launch edge into
// shadow registers, then a down-counter models the multi-cycle latency.
// HI/LO hold their old values while busy and take the shadow result on the
// counter's 1->0 edge.  Divide by zero runs the full latency but never
// commits.  MTHI/MTLO write directly when idle and not flushed.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   launch request for a multi-cycle op
//   md_op   in   [3:0] operation code (see md_defs::md_op_e)
//   A, B    in   [31:0] rs / rt operands
//   int_req in   flush: suppresses launches and MTHI/MTLO moves
//   busy    out  multi-cycle op in flight
//   HI, LO  out  [31:0] architectural HI/LO registers
//
// Build option: define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (codes
// 7..10); without it those codes behave as NONE.
module md_unit
  import md_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        int_req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_op_e op;
  assign op = md_op_e'(md_op);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic             sh_wr_q, sh_wr_d;

  // Arithmetic on the launch-edge operands
  logic signed [31:0] a_s, b_s, quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_nz;
`ifdef MD_MADD_EN
  logic        [63:0] acc;
  assign acc = {hi_q, lo_q};
`endif

  assign a_s    = $signed(A);
  assign b_s    = $signed(B);
  assign b_nz   = (B != 32'd0);
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  // Zero divisor is steered away so the divider never sees it; the result
  // is discarded anyway because sh_wr is cleared.
  assign quot_s = b_nz ? (a_s / b_s) : 32'sd0;
  assign rem_s  = b_nz ? (a_s % b_s) : 32'sd0;
  assign quot_u = b_nz ? (A / B) : 32'd0;
  assign rem_u  = b_nz ? (A % B) : 32'd0;

  logic [63:0]      res;
  logic [CNT_W-1:0] cycles;
  logic             op_ok;
  logic             res_wr;
  logic             launch;

  always_comb begin
    res    = 64'd0;
    cycles = '0;
    op_ok  = 1'b0;
    res_wr = 1'b1;
    case (op)
      MD_MULT: begin
        res    = prod_s;
        cycles = CNT_W'(MULT_CYCLES);
        op_ok  = 1'b1;
      end
      MD_MULTU: begin
        res    = prod_u;
        cycles = CNT_W'(MULT_CYCLES);
        op_ok  = 1'b1;
      end
      MD_DIV: begin
        res    = {rem_s, quot_s};
        res_wr = b_nz;
        cycles = CNT_W'(DIV_CYCLES);
        op_ok  = 1'b1;
      end
      MD_DIVU: begin
        res    = {rem_u, quot_u};
        res_wr = b_nz;
        cycles = CNT_W'(DIV_CYCLES);
        op_ok  = 1'b1;
      end
`ifdef MD_MADD_EN
      MD_MADD: begin
        res    = acc + prod_s;
        cycles = CNT_W'(MULT_CYCLES);
        op_ok  = 1'b1;
      end
      MD_MADDU: begin
        res    = acc + prod_u;
        cycles = CNT_W'(MULT_CYCLES);
        op_ok  = 1'b1;
      end
      MD_MSUB: begin
        res    = acc - prod_s;
        cycles = CNT_W'(MULT_CYCLES);
        op_ok  = 1'b1;
      end
      MD_MSUBU: begin
        res    = acc - prod_u;
        cycles = CNT_W'(MULT_CYCLES);
        op_ok  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy   = (cnt_q != '0);
  assign launch = start & ~busy & ~int_req & op_ok;

  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_wr_d = sh_wr_q;
    if (launch) begin
      cnt_d   = cycles;
      sh_hi_d = res[63:32];
      sh_lo_d = res[31:0];
      sh_wr_d = res_wr;
    end else if (busy) begin
      // In-flight op always runs to completion; int_req has no say here.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1) && sh_wr_q) begin
        hi_d = sh_hi_q;
        lo_d = sh_lo_q;
      end
    end else if (!int_req) begin
      if (op == MD_MTHI) hi_d = A;
      if (op == MD_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
      sh_wr_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_wr_q <= sh_wr_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: scoreboard of expected busy length and HI/LO
// results, filled when an op is issued and consumed when busy drops.
module tb_md_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MTHI = 4'd5,
                         OP_MTLO = 4'd6, OP_MADD = 4'd7, OP_MADDU = 4'd8,
                         OP_MSUB = 4'd9, OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset, start, int_req;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int passed = 0;
  int total  = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .int_req(int_req),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one start pulse given HI/LO at launch.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi,
                                input logic [31:0] lo, output int cyc,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint          sa, sb;
    longint unsigned ps, pu, acc;
    int              da, db;
    sa  = longint'({{32{a[31]}}, a});
    sb  = longint'({{32{b[31]}}, b});
    ps  = longint'(sa * sb);
    pu  = {32'd0, a} * {32'd0, b};
    acc = {hi, lo};
    da  = int'(a);
    db  = int'(b);
    ehi = hi;
    elo = lo;
    cyc = 0;
    case (op)
      OP_MULT:  begin cyc = 5; {ehi, elo} = ps; end
      OP_MULTU: begin cyc = 5; {ehi, elo} = pu; end
      OP_DIV: begin
        cyc = 10;
        if (b != 0) begin elo = 32'(da / db); ehi = 32'(da % db); end
      end
      OP_DIVU: begin
        cyc = 10;
        if (b != 0) begin elo = a / b; ehi = a % b; end
      end
`ifdef MD_MADD_EN
      OP_MADD:  begin cyc = 5; {ehi, elo} = acc + ps; end
      OP_MADDU: begin cyc = 5; {ehi, elo} = acc + pu; end
      OP_MSUB:  begin cyc = 5; {ehi, elo} = acc - ps; end
      OP_MSUBU: begin cyc = 5; {ehi, elo} = acc - pu; end
`endif
      default: ;
    endcase
  endfunction

  // Drive one start pulse and push its expected outcome.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    exp_t e;
    e.name = name;
    model(op, a, b, mdl_hi, mdl_lo, e.cyc, e.hi, e.lo);
    sb.push_back(e);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    step;
    start = 1'b0;
    md_op = OP_NONE;
  endtask

  // Pop the oldest expectation, count busy cycles and compare the commit.
  // already = busy cycles the caller stepped through since issue.
  task automatic score_next(input int already);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = already;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step;
    end
    total++;
    if (n !== e.cyc) $display("FAIL %s busy_len actual=%0d required=%0d", e.name, n, e.cyc);
    else passed++;
    total++;
    if (HI !== e.hi) $display("FAIL %s HI actual=%h required=%h", e.name, HI, e.hi);
    else passed++;
    total++;
    if (LO !== e.lo) $display("FAIL %s LO actual=%h required=%h", e.name, LO, e.lo);
    else passed++;
    mdl_hi = e.hi;
    mdl_lo = e.lo;
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] v);
    md_op = op;
    A     = v;
    step;
    md_op = OP_NONE;
    if (op == OP_MTHI) mdl_hi = v;
    else mdl_lo = v;
  endtask

  task automatic test_reset;
    step;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy);
    else passed++;
    total++;
    if (HI !== 32'd0) $display("FAIL reset_hi actual=%h required=00000000", HI);
    else passed++;
    total++;
    if (LO !== 32'd0) $display("FAIL reset_lo actual=%h required=00000000", LO);
    else passed++;
    reset = 1'b0;
    step;
  endtask

  task automatic test_mult;
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2, "mult");
    score_next(0);
    total++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFE) $display("FAIL mult_const actual=%h%h required=fffffffffffffffe", HI, LO);
    else passed++;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, "multu");
    score_next(0);
    total++;
    if ({HI, LO} !== 64'h00000001_FFFFFFFE) $display("FAIL multu_const actual=%h%h required=00000001fffffffe", HI, LO);
    else passed++;
  endtask

  task automatic test_div;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
    score_next(0);
    total++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_const actual=%h%h required=fffffffffffffffd", HI, LO);
    else passed++;
    issue(OP_DIVU, 32'd7, 32'd0, "divu_by_zero");
    score_next(0);
    issue(OP_DIV, 32'd100, 32'hFFFFFFF9, "div_negdivisor");
    score_next(0);
  endtask

  task automatic test_mthi_busy;
    logic [31:0] old_hi;
    issue(OP_MULT, 32'd6, 32'd7, "mult_under_mthi");
    old_hi = mdl_hi;
    step;                                  // busy cycle 2
    md_op = OP_MTHI;
    A     = 32'h12345678;
    step;                                  // busy cycle 3
    md_op = OP_NONE;
    total++;
    if (HI !== old_hi) $display("FAIL mthi_while_busy actual=%h required=%h", HI, old_hi);
    else passed++;
    start = 1'b1;                          // second start while busy
    md_op = OP_MULT;
    A     = 32'd5;
    B     = 32'd5;
    step;                                  // busy cycle 4
    start = 1'b0;
    md_op = OP_NONE;
    score_next(3);
    move(OP_MTHI, 32'h12345678);
    total++;
    if (HI !== 32'h12345678) $display("FAIL mthi_idle actual=%h required=12345678", HI);
    else passed++;
    move(OP_MTLO, 32'hA5A5_0001);
    total++;
    if (LO !== 32'hA5A5_0001) $display("FAIL mtlo_idle actual=%h required=a5a50001", LO);
    else passed++;
  endtask

  task automatic test_int_req;
    int_req = 1'b1;
    start   = 1'b1;
    md_op   = OP_MULT;
    A       = 32'd9;
    B       = 32'd9;
    step;
    start   = 1'b0;
    md_op   = OP_NONE;
    total++;
    if (busy !== 1'b0) $display("FAIL int_req_launch busy actual=%b required=0", busy);
    else passed++;
    md_op = OP_MTLO;                       // move under flush is suppressed
    A     = 32'hDEAD0000;
    step;
    md_op   = OP_NONE;
    int_req = 1'b0;
    total++;
    if ({HI, LO} !== {mdl_hi, mdl_lo}) $display("FAIL int_req_hold actual=%h%h required=%h%h", HI, LO, mdl_hi, mdl_lo);
    else passed++;
    issue(OP_MULTU, 32'd1000, 32'd3000, "mult_int_req_mid");
    step;                                  // busy cycle 2
    step;                                  // busy cycle 3
    int_req = 1'b1;
    step;
    int_req = 1'b0;
    score_next(3);
  endtask

  task automatic test_nop_codes;
    logic [3:0] codes [6];
    codes = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    foreach (codes[i]) begin
      issue(codes[i], 32'hFFFF0000, 32'd3, $sformatf("nop_code_%0d", codes[i]));
      score_next(0);
    end
  endtask

  task automatic test_reset_mid;
    exp_t dropped;
    move(OP_MTHI, 32'h0BAD_F00D);
    issue(OP_MULT, 32'd3, 32'd4, "mult_reset_mid");
    step;                                  // busy cycle 2
    #2 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL reset_mid_immediate actual=busy %b HI %h LO %h required=0/0/0", busy, HI, LO);
    else passed++;
    dropped = sb.pop_front();
    mdl_hi  = 32'd0;
    mdl_lo  = 32'd0;
    step;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step;
    total++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL reset_mid_no_commit (%s) actual=busy %b HI %h LO %h required=0/0/0", dropped.name, busy, HI, LO);
    else passed++;
  endtask

  task automatic test_madd;
    move(OP_MTHI, 32'd0);
    move(OP_MTLO, 32'd1);
    issue(OP_MADD, 32'd2, 32'd3, "madd");
    score_next(0);
    total++;
`ifdef MD_MADD_EN
    if (LO !== 32'd7) $display("FAIL madd_const actual=%h required=00000007", LO);
    else passed++;
`else
    if (LO !== 32'd1) $display("FAIL madd_disabled actual=%h required=00000001", LO);
    else passed++;
`endif
    issue(OP_MSUBU, 32'd5, 32'd1, "msubu");
    score_next(0);
    issue(OP_MSUB, 32'hFFFFFFFF, 32'd4, "msub");
    score_next(0);
    issue(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, "maddu");
    score_next(0);
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [8];
    logic [31:0] a, b;
    logic [3:0]  op;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 3) b = {28'd0, b[3:0]};
      if (a == 32'h80000000) a = 32'd1;
      issue(op, a, b, $sformatf("b2b_%0d_op%0d", i, op));
      score_next(0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    int_req = 1'b0;
    md_op   = OP_NONE;
    A       = 32'd0;
    B       = 32'd0;
    test_reset;
    test_mult;
    test_div;
    test_mthi_busy;
    test_int_req;
    test_nop_codes;
    test_reset_mid;
    test_madd;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
